// File: rtl/centroid_line_sequencer.sv
// Captures one sensor line, hands its peak and a replay of the line to centroid_finder,
// then returns the finder's centroid (or a timeout / no-peak result) over a valid/ready port.
module centroid_line_sequencer #(
    parameter int LINE_LEN    = 512,
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 10,
    parameter int TIMEOUT_CYC = 255,
    parameter int MIN_PEAK    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_value,
    output logic              cf_start,
    output logic [ADDR_W-1:0] cf_max_pos,
    output logic [DATA_W-1:0] cf_max_value,
    output logic              cf_data_valid,
    output logic [ADDR_W-1:0] cf_adress,
    output logic [DATA_W-1:0] cf_value,
    input  logic              cf_done,
    input  logic [15:0]       cf_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [1:0]        res_flags,
    output logic [15:0]       overrun_cnt,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_START,
        ST_REPLAY,
        ST_WAIT_DONE,
        ST_OUTPUT
    } state_t;

    localparam logic [ADDR_W:0] LEN_C    = (ADDR_W+1)'(LINE_LEN);
    localparam logic [ADDR_W:0] LAST_C   = (ADDR_W+1)'(LINE_LEN - 1);
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state;
    logic [DATA_W-1:0] line_buf [LINE_LEN];
    logic [ADDR_W:0]   idx;
    logic [ADDR_W-1:0] peak_pos;
    logic [DATA_W-1:0] peak_val;
    logic [7:0]        tmo_cnt;

    logic              wr_en;
    logic              last_pix;
    logic              take_peak;
    logic [DATA_W-1:0] fin_val;
    logic [ADDR_W-1:0] fin_pos;

    // Peak including the pixel arriving this cycle, so the last pixel of a line is not missed.
    assign wr_en     = (state == ST_CAPTURE) && pix_valid;
    assign last_pix  = wr_en && (idx == LAST_C);
    assign take_peak = wr_en && (pix_value > peak_val);
    assign fin_val   = take_peak ? pix_value : peak_val;
    assign fin_pos   = take_peak ? idx[ADDR_W-1:0] : peak_pos;
    assign busy      = (state != ST_IDLE);

    // NOTE: the line buffer is deliberately left out of reset so it maps onto block RAM;
    // its contents are never observed before being written by a capture.
    always_ff @(posedge clk) begin
        if (wr_en) line_buf[idx[ADDR_W-1:0]] <= pix_value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            idx           <= '0;
            peak_pos      <= '0;
            peak_val      <= '0;
            tmo_cnt       <= '0;
            cf_start      <= 1'b0;
            cf_max_pos    <= '0;
            cf_max_value  <= '0;
            cf_data_valid <= 1'b0;
            cf_adress     <= '0;
            cf_value      <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_flags     <= '0;
            overrun_cnt   <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the cycle that needs them.
            cf_start <= 1'b0;

            // In CAPTURE a line_start either restarts the line or, with the last pixel, is dropped.
            if (line_start && (state != ST_IDLE) && (overrun_cnt != 16'hFFFF))
                overrun_cnt <= overrun_cnt + 16'd1;

            case (state)
                ST_IDLE: begin
                    if (line_start) begin
                        state    <= ST_CAPTURE;
                        idx      <= '0;
                        peak_val <= '0;
                        peak_pos <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (last_pix) begin
                        if (int'(fin_val) < MIN_PEAK) begin
                            state     <= ST_OUTPUT;
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_flags <= 2'b10;
                        end else begin
                            state        <= ST_START;
                            cf_start     <= 1'b1;
                            cf_max_pos   <= fin_pos;
                            cf_max_value <= fin_val;
                        end
                    end else if (line_start) begin
                        idx      <= '0;
                        peak_val <= '0;
                        peak_pos <= '0;
                    end else if (pix_valid) begin
                        idx      <= idx + 1'b1;
                        peak_val <= fin_val;
                        peak_pos <= fin_pos;
                    end
                end
                ST_START: begin
                    state <= ST_REPLAY;
                    idx   <= '0;
                end
                ST_REPLAY: begin
                    // Address and strobe travel with the registered read so cf_value matches cf_adress.
                    if (idx == LEN_C) begin
                        cf_data_valid <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= ST_WAIT_DONE;
                    end else begin
                        cf_data_valid <= 1'b1;
                        cf_adress     <= idx[ADDR_W-1:0];
                        cf_value      <= line_buf[idx[ADDR_W-1:0]];
                        idx           <= idx + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (cf_done) begin
                        res_data  <= cf_result;
                        res_flags <= 2'b00;
                        res_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_data  <= '0;
                        res_flags <= 2'b01;
                        res_valid <= 1'b1;
                        state     <= ST_OUTPUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_line_sequencer.sv
// Directed bench for centroid_line_sequencer: a finder model answers start/replay/done,
// and replayed pixels and results are compared against queues filled as stimulus is driven.
module tb_centroid_line_sequencer;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  flags;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [9:0]  pix_value = '0;
    logic        sel_b = 1'b0;
    logic        cf_done = 1'b0;
    logic [15:0] cf_result = '0;
    logic        res_ready = 1'b0;
    logic        b_res_ready = 1'b0;

    logic        a_line_start, a_pix_valid, b_line_start, b_pix_valid;
    assign a_line_start = line_start & ~sel_b;
    assign a_pix_valid  = pix_valid & ~sel_b;
    assign b_line_start = line_start & sel_b;
    assign b_pix_valid  = pix_valid & sel_b;

    logic        cf_start, cf_data_valid, res_valid, busy;
    logic [8:0]  cf_max_pos, cf_adress;
    logic [9:0]  cf_max_value, cf_value;
    logic [15:0] res_data, overrun_cnt;
    logic [1:0]  res_flags;

    logic        b_cf_start, b_cf_data_valid, b_res_valid, b_busy;
    logic [8:0]  b_cf_max_pos, b_cf_adress;
    logic [9:0]  b_cf_max_value, b_cf_value;
    logic [15:0] b_res_data, b_overrun_cnt;
    logic [1:0]  b_res_flags;

    centroid_line_sequencer dut (
        .clk(clk), .rst_n(rst_n), .line_start(a_line_start), .pix_valid(a_pix_valid),
        .pix_value(pix_value), .cf_start(cf_start), .cf_max_pos(cf_max_pos),
        .cf_max_value(cf_max_value), .cf_data_valid(cf_data_valid), .cf_adress(cf_adress),
        .cf_value(cf_value), .cf_done(cf_done), .cf_result(cf_result), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
        .overrun_cnt(overrun_cnt), .busy(busy)
    );

    centroid_line_sequencer #(.MIN_PEAK(100)) dut_b (
        .clk(clk), .rst_n(rst_n), .line_start(b_line_start), .pix_valid(b_pix_valid),
        .pix_value(pix_value), .cf_start(b_cf_start), .cf_max_pos(b_cf_max_pos),
        .cf_max_value(b_cf_max_value), .cf_data_valid(b_cf_data_valid), .cf_adress(b_cf_adress),
        .cf_value(b_cf_value), .cf_done(1'b0), .cf_result(16'h0000), .res_valid(b_res_valid),
        .res_ready(b_res_ready), .res_data(b_res_data), .res_flags(b_res_flags),
        .overrun_cnt(b_overrun_cnt), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] line_px [512];
    logic [9:0] exp_pix [$];
    res_t       exp_res [$];

    bit          finder_respond = 1'b1;
    logic [15:0] finder_result = '0;
    int          replay_cnt = 0;
    int          done_wait = -1;
    bit          hold_checked = 1'b0;
    int          b_start_cnt = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Finder model: clears done on start, checks every replay strobe, answers after a short delay.
    always @(negedge clk) begin
        if (!rst_n) begin
            replay_cnt   = 0;
            done_wait    = -1;
            cf_done      = 1'b0;
            hold_checked = 1'b0;
        end else begin
            if (cf_start) begin
                cf_done      = 1'b0;
                replay_cnt   = 0;
                done_wait    = -1;
                hold_checked = 1'b0;
            end
            if (cf_data_valid) begin
                if (exp_pix.size() == 0) begin
                    check("replay_extra", 1, 0);
                end else begin
                    logic [9:0] ev;
                    ev = exp_pix.pop_front();
                    check("replay_addr_val", {cf_adress, cf_value}, {9'(replay_cnt), ev});
                end
                replay_cnt++;
                if (replay_cnt == 512 && finder_respond) done_wait = 6;
            end else if (replay_cnt == 512 && !hold_checked) begin
                check("replay_addr_hold", cf_adress, 9'd511);
                hold_checked = 1'b1;
            end
            if (done_wait > 0) begin
                done_wait--;
            end else if (done_wait == 0) begin
                cf_done   = 1'b1;
                cf_result = finder_result;
                done_wait = -1;
            end
        end
    end

    // Result scoreboard: sampled mid-cycle so the handshake seen is the one the next edge takes.
    always @(negedge clk) begin
        #1;
        if (rst_n && res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                res_t e;
                e = exp_res.pop_front();
                check("res_data", res_data, e.data);
                check("res_flags", res_flags, e.flags);
            end
        end
    end

    always @(negedge clk) if (b_cf_start) b_start_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_line();
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int i = 0; i < 512; i++) begin
            pix_valid = 1'b1;
            pix_value = line_px[i];
            if (!sel_b) exp_pix.push_back(line_px[i]);
            @(negedge clk);
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic ramp_line(input int peak_at, input logic [9:0] peak_v);
        for (int i = 0; i < 512; i++) line_px[i] = 10'(i);
        line_px[peak_at] = peak_v;
    endtask

    initial begin
        int n;
        int cnt;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {cf_start, cf_max_pos, cf_max_value, cf_data_valid, cf_adress, cf_value,
               res_valid, res_data, res_flags, overrun_cnt, busy}, 0);
        rst_n     = 1'b1;
        res_ready = 1'b1;

        // 1: ramp with a single peak at 200
        ramp_line(200, 10'd1000);
        finder_respond = 1'b1;
        finder_result  = 16'h6400;
        exp_res.push_back('{data: 16'h6400, flags: 2'b00});
        send_line();
        check("t1_start", cf_start, 1);
        check("t1_pos", cf_max_pos, 200);
        check("t1_val", cf_max_value, 1000);
        wait_idle("t1");
        check("t1_strobes", replay_cnt, 512);

        // 2: two equal peaks, first occurrence wins
        for (int i = 0; i < 512; i++) line_px[i] = 10'(i % 256);
        line_px[50]  = 10'd900;
        line_px[300] = 10'd900;
        finder_result = 16'h1234;
        exp_res.push_back('{data: 16'h1234, flags: 2'b00});
        send_line();
        check("t2_pos", cf_max_pos, 50);
        check("t2_val", cf_max_value, 900);
        wait_idle("t2");

        // 3: finder never answers -> timeout after 255 WAIT_DONE cycles
        ramp_line(17, 10'd700);
        finder_respond = 1'b0;
        exp_res.push_back('{data: 16'h0000, flags: 2'b01});
        send_line();
        check("t3_pos", cf_max_pos, 17);
        n = 0;
        while (!cf_data_valid && n < 20) begin @(negedge clk); n++; end
        while (cf_data_valid && n < 700) begin @(negedge clk); n++; end
        cnt = 0;
        while (!res_valid && cnt < 1000) begin cnt++; @(negedge clk); end
        check("t3_wait_cycles", cnt, 255);
        wait_idle("t3");
        finder_respond = 1'b1;

        // 4: peak below MIN_PEAK on the second instance -> finder skipped
        sel_b = 1'b1;
        for (int i = 0; i < 512; i++) line_px[i] = 10'd20;
        send_line();
        check("t4_valid", b_res_valid, 1);
        check("t4_data", b_res_data, 0);
        check("t4_flags", b_res_flags, 2'b10);
        b_res_ready = 1'b1;
        @(negedge clk);
        check("t4_idle", {b_res_valid, b_busy}, 0);
        check("t4_no_start", b_start_cnt, 0);
        sel_b       = 1'b0;
        b_res_ready = 1'b0;

        // 5: back-pressure with three dropped lines
        ramp_line(400, 10'd999);
        finder_result = 16'hBEEF;
        res_ready     = 1'b0;
        exp_res.push_back('{data: 16'hBEEF, flags: 2'b00});
        send_line();
        n = 0;
        while (!res_valid && n < 1200) begin @(negedge clk); n++; end
        for (int k = 0; k < 40; k++) begin
            check("t5_hold", {res_valid, res_flags, res_data}, {1'b1, 2'b00, 16'hBEEF});
            line_start = (k == 5 || k == 15 || k == 25);
            @(negedge clk);
        end
        line_start = 1'b0;
        check("t5_overrun", overrun_cnt, 3);
        res_ready = 1'b1;
        @(negedge clk);
        check("t5_after_accept", {res_valid, busy}, 0);

        // 7: restart mid-capture drops the partial line and its peak
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            pix_valid = 1'b1;
            pix_value = (i == 10) ? 10'd1000 : 10'd5;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        for (int i = 0; i < 512; i++) line_px[i] = 10'(i % 256);
        finder_result = 16'h0777;
        exp_res.push_back('{data: 16'h0777, flags: 2'b00});
        send_line();
        check("t7_pos", cf_max_pos, 255);
        check("t7_val", cf_max_value, 255);
        check("t7_overrun", overrun_cnt, 4);
        wait_idle("t7");

        // 6: reset in the middle of replay, then a clean line
        ramp_line(321, 10'd888);
        send_line();
        n = 0;
        while (!(cf_data_valid && cf_adress == 9'd137) && n < 700) begin @(negedge clk); n++; end
        check("t6_reached_137", cf_adress, 137);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs",
              {cf_start, cf_max_pos, cf_max_value, cf_data_valid, cf_adress, cf_value,
               res_valid, res_data, res_flags, overrun_cnt, busy}, 0);
        exp_pix.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ramp_line(200, 10'd1000);
        finder_result = 16'h0ABC;
        exp_res.push_back('{data: 16'h0ABC, flags: 2'b00});
        send_line();
        check("t6_pos", cf_max_pos, 200);
        wait_idle("t6");

        check("results_drained", exp_res.size(), 0);
        check("pixels_drained", exp_pix.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
